// File: rtl/ecc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ecc_pkg
// Description : Shared types, widths and the (72,64) SECDED position-to-check
//               bit mask table used by the Hamming encoder and decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package ecc_pkg;

  // Data word width (only 64 is supported by the code tables below)
  localparam int DATA_W = 64;
  // Stored parity width: seven Hamming check bits plus overall parity
  localparam int PAR_W  = 8;
  // Number of Hamming check bits (p0..p6)
  localparam int CHK_W  = 7;
  // Highest codeword position used by the Hamming part of the code
  localparam int CW_POS_MAX = 71;

  typedef logic [DATA_W-1:0] pattern_t;
  typedef logic [PAR_W-1:0]  parity_t;
  typedef logic [CHK_W-1:0]  check_t;

  // One DATA_W-bit mask per check bit; bit i set means data bit i feeds p_k
  typedef logic [CHK_W-1:0][DATA_W-1:0] mask_tbl_t;

  // Codeword position (1..71) that data bit idx occupies. Check bits sit on
  // the powers of two, data fills every other position in ascending order.
  function automatic logic [CHK_W-1:0] data_pos(input int unsigned idx);
    int unsigned di;
    logic [CHK_W-1:0] res;
    di  = 0;
    res = '0;
    for (int unsigned pos = 1; pos <= CW_POS_MAX; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (di == idx) begin
          res = CHK_W'(pos);
        end
        di++;
      end
    end
    return res;
  endfunction

  // Builds the per-check-bit data masks from the codeword position layout
  function automatic mask_tbl_t build_check_mask();
    mask_tbl_t tbl;
    int unsigned di;
    tbl = '0;
    di  = 0;
    for (int unsigned pos = 1; pos <= CW_POS_MAX; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        for (int unsigned k = 0; k < CHK_W; k++) begin
          if (((pos >> k) & 1) != 0) begin
            tbl[k][di] = 1'b1;
          end
        end
        di++;
      end
    end
    return tbl;
  endfunction

  // Position-to-check-bit mask table shared by encoder and decoder
  localparam mask_tbl_t CHECK_MASK = build_check_mask();

endpackage : ecc_pkg
`default_nettype wire

// File: rtl/hamming_par_tree.sv
`default_nettype none
// ============================================================================
// Module      : hamming_par_tree
// Description : Purely combinational XOR trees, one per Hamming check bit.
//               The encoder uses it to form p0..p6; the decoder can reuse it
//               on received data to build the syndrome.
// Revision    : 1.0 - initial release
// ============================================================================
module hamming_par_tree
  import ecc_pkg::*;
(
  input  pattern_t data_i,
  output check_t   check_o
);

  // Each check bit is the XOR of the data bits whose position has bit k set
  for (genvar k = 0; k < CHK_W; k++) begin : g_chk
    assign check_o[k] = ^(data_i & CHECK_MASK[k]);
  end

endmodule : hamming_par_tree
`default_nettype wire

// File: rtl/hamming_enc.sv
`default_nettype none
// ============================================================================
// Module      : hamming_enc
// Description : Two-stage pipelined (72,64) SECDED encoder with valid/ready
//               handshakes, per-word bypass and a saturating output counter.
//               Stage 1 holds data plus the seven check bits, stage 2 holds
//               the final parity byte including the overall parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
module hamming_enc
  import ecc_pkg::*;
#(
  parameter int DATA_W = ecc_pkg::DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  pattern_t         i_pattern,
  input  logic             i_valid,
  output logic             o_ready,
  output pattern_t         o_pattern,
  output parity_t          o_parity,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [CNT_W-1:0] o_count
);

  // --------------------------------------------------------------------------
  // Handshake / advance logic
  // --------------------------------------------------------------------------
  logic w_s1_adv;
  logic w_s2_adv;
  logic w_in_xfer;
  logic w_out_xfer;

  // Stage 1 state
  logic     s1_valid_q, s1_valid_d;
  pattern_t s1_data_q,  s1_data_d;
  check_t   s1_chk_q,   s1_chk_d;
  logic     s1_en_q,    s1_en_d;

  // Stage 2 state (drives the outputs directly)
  logic     s2_valid_q, s2_valid_d;
  pattern_t s2_data_q,  s2_data_d;
  parity_t  s2_par_q,   s2_par_d;

  // Delivered-word counter
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Stage 2 frees up whenever it is empty or its word is taken downstream;
  // stage 1 can then move forward, which is exactly when a new word fits.
  assign w_s2_adv   = !s2_valid_q || i_ready;
  assign w_s1_adv   = !s1_valid_q || w_s2_adv;
  assign w_in_xfer  = i_valid && w_s1_adv;
  assign w_out_xfer = s2_valid_q && i_ready;

  // Reset empties the pipeline, so ready is reported high while it is held;
  // the reset branch of the register process still blocks the transfer.
  assign o_ready = i_rst || w_s1_adv;

  // --------------------------------------------------------------------------
  // Check-bit generation
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] w_data_in;
  check_t            w_chk;
  logic              w_overall;
  parity_t           w_s2_par;

  assign w_data_in = i_pattern;

  hamming_par_tree u_par_tree (
    .data_i  (w_data_in),
    .check_o (w_chk)
  );

  // Overall bit makes the full 72-bit codeword even parity; bypassed words
  // carry an all-zero parity byte.
  assign w_overall = (^s1_data_q) ^ (^s1_chk_q);
  assign w_s2_par  = s1_en_q ? {w_overall, s1_chk_q} : '0;

  // --------------------------------------------------------------------------
  // Next-state logic for both pipeline stages and the counter
  // --------------------------------------------------------------------------
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_chk_d   = s1_chk_q;
    s1_en_d    = s1_en_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_par_d   = s2_par_q;
    cnt_d      = cnt_q;

    if (w_s1_adv) begin
      s1_valid_d = w_in_xfer;
      if (w_in_xfer) begin
        s1_data_d = i_pattern;
        s1_chk_d  = w_chk;
        s1_en_d   = i_en;
      end
    end

    // Outputs only change when a real word moves in, so a bubble or a stall
    // leaves the last pattern/parity on the bus.
    if (w_s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = s1_data_q;
        s2_par_d  = w_s2_par;
      end
    end

    if (w_out_xfer && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Pipeline and counter registers with synchronous reset
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_chk_q   <= '0;
      s1_en_q    <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_par_q   <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_chk_q   <= s1_chk_d;
      s1_en_q    <= s1_en_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_par_q   <= s2_par_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_valid   = s2_valid_q;
  assign o_pattern = s2_data_q;
  assign o_parity  = s2_par_q;
  assign o_count   = cnt_q;

endmodule : hamming_enc
`default_nettype wire

// File: doc/hamming_enc.md
HAMMING_ENC -- requirements
Module: hamming_enc

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning data width (fixed by package constant; only 64 supported).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the encoded-word counter.
REQ-003 i_clk  input  1  sole clock; all logic on rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_en  input  1  encode enable; 0 = bypass (data passes, parity forced 0x00).
REQ-006 i_pattern  input  pattern_t (64)  data word to encode.
REQ-007 i_valid  input  1  i_pattern valid.
REQ-008 o_ready  output  1  encoder can accept a word this cycle.
REQ-009 o_pattern  output  pattern_t (64)  data word aligned with o_parity.
REQ-010 o_parity  output  parity_t (8)  [6:0] Hamming check bits p0..p6, [7] overall parity.
REQ-011 o_valid  output  1  o_pattern/o_parity valid.
REQ-012 i_ready  input  1  downstream accepts output this cycle.
REQ-013 o_count  output  CNT_W  number of encoded words delivered, saturating.

Function
REQ-014 Code SHALL be (72,64) SECDED: codeword positions 1..71, check bits at positions 1,2,4,8,16,32,64, data bits 0..63 filling remaining positions in ascending order.
REQ-015 p_k SHALL equal XOR of data bits whose codeword position has bit k set, k=0..6.
REQ-016 o_parity[7] SHALL equal XOR of all 64 data bits and p0..p6 (even parity over 72 bits).
REQ-017 Input transfer SHALL occur when i_valid && o_ready; output transfer when o_valid && i_ready.
REQ-018 Pipeline SHALL be 2 stages: stage 1 registers data and seven partial XOR-tree results, stage 2 registers final parity incl. overall bit; latency input transfer to o_valid = 2 cycles with no backpressure.
REQ-019 Each stage SHALL hold a valid flag; a stage SHALL advance when it is empty or the next stage advances (stage 2 advances on i_ready).
REQ-020 o_ready SHALL equal !s1_valid || !s2_valid || i_ready; sustained throughput 1 word/cycle with i_ready=1.
REQ-021 With o_valid=1 and i_ready=0, o_pattern and o_parity SHALL remain stable until transfer.
REQ-022 i_en SHALL be sampled with the word at input transfer and carried through the pipeline; mid-stream toggling affects only words accepted afterward.
REQ-023 No word SHALL be dropped or duplicated under any i_valid/i_ready pattern.
REQ-024 o_count SHALL increment by 1 on each output transfer and saturate at 2^CNT_W-1.
REQ-025 Simultaneous input and output transfer with both stages full SHALL shift the pipeline and accept the new word in the same cycle.

Reset
REQ-026 On i_rst=1 at a clock edge, both stage valid flags, o_valid, o_count SHALL clear to 0; o_pattern, o_parity SHALL clear to 0.
REQ-027 During reset o_ready SHALL be 1 (pipeline empty) but no input transfer SHALL be taken; words in flight at reset SHALL be discarded.

Structure
REQ-028 pattern_t, parity_t, DATA_W=64, PAR_W=8 and the position-to-check-bit mask table SHALL live in shared package ecc_pkg, also used by hamming_dec.
REQ-029 Parity computation SHALL be one sub-module hamming_par_tree (combinational XOR-tree per check bit), instantiable by the decoder for syndrome generation.

Verification
REQ-030 Data 0x0, i_en=1, i_ready=1 -> o_parity 0x00, o_valid 2 cycles after input.
REQ-031 Data 0x1 -> 0x83; data 0x2 -> 0x85; data 0x3 -> 0x06.
REQ-032 Data 0x3 with i_en=0 -> o_pattern 0x3, o_parity 0x00.
REQ-033 Back-to-back 8 words, i_ready toggling 1/0 each cycle -> all 8 delivered in order, held stable while stalled, o_count=8.
REQ-034 i_rst asserted with 2 words in flight -> next cycle o_valid=0, o_count=0, no stale word later emitted.
REQ-035 CNT_W=4, 20 transfers -> o_count saturates at 15.
